// File: rtl/audio_sequencer_if.sv
// Bundle between game logic (master) and the sound sequencer (slave):
// play/stop requests and sample strobe in, ROM address and playback status out.
interface audio_sequencer_if #(
   parameter int N_SOUNDS = 4,
   parameter int ADDR_W   = 15
);
   localparam int ID_W = (N_SOUNDS > 1) ? $clog2(N_SOUNDS) : 1;

   logic                clk_8KHZ;
   logic [N_SOUNDS-1:0] req;
   logic                stop;
   logic [ADDR_W-1:0]   rom_addr;
   logic                sample_en;
   logic [ID_W-1:0]     sound_id;
   logic                busy;
   logic                done;

   modport master (
      output clk_8KHZ, req, stop,
      input  rom_addr, sample_en, sound_id, busy, done
   );

   modport slave (
      input  clk_8KHZ, req, stop,
      output rom_addr, sample_en, sound_id, busy, done
   );
endinterface

// File: rtl/audio_sequencer.sv
// Fixed-priority sound scheduler with preemption/queueing; steps the sample-ROM
// address on each 8 kHz strobe. Request to first sample: IDLE + LOAD = 2 cycles.
module audio_sequencer #(
   parameter int                           N_SOUNDS   = 4,
   parameter int                           ADDR_W     = 15,
   parameter logic [N_SOUNDS*ADDR_W-1:0]   SOUND_BASE = '0,
   parameter logic [N_SOUNDS*ADDR_W-1:0]   SOUND_LEN  = '0,
   parameter logic [N_SOUNDS-1:0]          LOOP_MASK  = '0
) (
   input  logic             clk_25MHZ,
   input  logic             rst,
   audio_sequencer_if.slave snd
);
   localparam int                ID_W     = (N_SOUNDS > 1) ? $clog2(N_SOUNDS) : 1;
   localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

   typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_t;

   state_t              state_q, state_d;
   logic [N_SOUNDS-1:0] pending_q, pending_d;
   logic [ID_W-1:0]     sound_id_q, sound_id_d;
   logic [ADDR_W-1:0]   offset_q, offset_d;
   logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
   logic                done_q, done_d;

   logic [N_SOUNDS-1:0] cand;
   logic [ID_W-1:0]     cand_top;
   logic [ID_W-1:0]     req_top;
   logic                req_any;

   function automatic logic [ID_W-1:0] top_idx(input logic [N_SOUNDS-1:0] v);
      top_idx = '0;
      for (int i = 0; i < N_SOUNDS; i++) begin
         if (v[i]) top_idx = ID_W'(i);
      end
   endfunction

   function automatic logic [N_SOUNDS-1:0] onehot(input logic [ID_W-1:0] idx);
      onehot      = '0;
      onehot[idx] = 1'b1;
   endfunction

   function automatic logic [ADDR_W-1:0] base_of(input logic [ID_W-1:0] id);
      base_of = SOUND_BASE[int'(id)*ADDR_W +: ADDR_W];
   endfunction

   function automatic logic [ADDR_W-1:0] last_of(input logic [ID_W-1:0] id);
      last_of = SOUND_LEN[int'(id)*ADDR_W +: ADDR_W] - ADDR_ONE;
   endfunction

   always_comb begin
      state_d    = state_q;
      pending_d  = pending_q | snd.req;
      sound_id_d = sound_id_q;
      offset_d   = offset_q;
      rom_addr_d = rom_addr_q;
      done_d     = 1'b0;
      cand       = pending_q | snd.req;
      cand_top   = top_idx(cand);
      req_top    = top_idx(snd.req);
      req_any    = |snd.req;

      if (snd.stop) begin
         state_d   = IDLE;
         pending_d = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (|cand) begin
                  state_d    = LOAD;
                  sound_id_d = cand_top;
                  pending_d  = cand & ~onehot(cand_top);
               end
            end
            LOAD: begin
               state_d    = PLAY;
               offset_d   = '0;
               rom_addr_d = base_of(sound_id_q);
            end
            PLAY: begin
               if (req_any && req_top > sound_id_q) begin
                  // A looping victim goes back in the queue; a one-shot is dropped.
                  state_d    = LOAD;
                  sound_id_d = req_top;
                  pending_d  = (pending_q | snd.req) & ~onehot(req_top);
                  if (LOOP_MASK[sound_id_q]) pending_d = pending_d | onehot(sound_id_q);
               end else if (req_any && req_top == sound_id_q) begin
                  pending_d  = (pending_q | snd.req) & ~onehot(req_top);
                  offset_d   = '0;
                  rom_addr_d = base_of(sound_id_q);
               end else if (snd.clk_8KHZ) begin
                  if (offset_q < last_of(sound_id_q)) begin
                     offset_d   = offset_q + ADDR_ONE;
                     rom_addr_d = base_of(sound_id_q) + offset_q + ADDR_ONE;
                  end else if (LOOP_MASK[sound_id_q]) begin
                     offset_d   = '0;
                     rom_addr_d = base_of(sound_id_q);
                  end else begin
                     state_d = IDLE;
                     done_d  = 1'b1;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_25MHZ) begin
      if (rst) begin
         state_q    <= IDLE;
         pending_q  <= '0;
         sound_id_q <= '0;
         offset_q   <= '0;
         rom_addr_q <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         pending_q  <= pending_d;
         sound_id_q <= sound_id_d;
         offset_q   <= offset_d;
         rom_addr_q <= rom_addr_d;
         done_q     <= done_d;
      end
   end

   assign snd.rom_addr  = rom_addr_q;
   assign snd.sample_en = (state_q == PLAY);
   assign snd.busy      = (state_q != IDLE);
   assign snd.sound_id  = sound_id_q;
   assign snd.done      = done_q;
endmodule

// File: doc/audio_sequencer.md
Name: audio_sequencer

Overview:
Schedules which sound the audio datapath plays and generates the sample-ROM address. Accepts one-cycle play requests from game logic for N_SOUNDS sound types in a single concatenated sample ROM, arbitrates by fixed priority with preemption and queueing, and advances the address on the 8 kHz sample strobe. Sits between game-state logic and the sample ROM / pwm stage; drives the ROM address and the audio enable.

Parameters:
N_SOUNDS, 4, number of sound types; index N_SOUNDS-1 has highest priority
ADDR_W, 15, sample-ROM address width
SOUND_BASE, 0, packed N_SOUNDS*ADDR_W; field i = first ROM address of sound i
SOUND_LEN, 0, packed N_SOUNDS*ADDR_W; field i = sample count of sound i (>=1)
LOOP_MASK, 0, N_SOUNDS bits; bit i set = sound i loops until stopped or preempted

Ports:
clk_25MHZ  input  1  system clock
rst  input  1  synchronous active-high reset
clk_8KHZ  input  1  sample strobe, one clk_25MHZ cycle wide, 8 kHz
req  input  N_SOUNDS  one-cycle play request pulses, one bit per sound
stop  input  1  abort current sound and clear all pending requests
rom_addr  output  ADDR_W  sample-ROM address
sample_en  output  1  high while a sound is playing; gates pwm / audio enable
sound_id  output  $clog2(N_SOUNDS)  index of sound being played
busy  output  1  high in LOAD or PLAY
done  output  1  one-cycle pulse when a non-looping sound finishes naturally

Behaviour:
- Reset (rst high at clock edge): state IDLE; rom_addr=0, sample_en=0, sound_id=0, busy=0, done=0, offset=0, pending=0. Reset mid-playback aborts immediately.
- States: IDLE, LOAD, PLAY.
- pending: N_SOUNDS-bit register; each cycle pending |= req (except as below).
- IDLE: if (pending|req) != 0, select highest set index k, clear bit k, sound_id<=k, -> LOAD. Else stay.
- LOAD (1 cycle): offset<=0, rom_addr<=BASE[k], -> PLAY. sample_en rises entering PLAY.
- PLAY: rom_addr = BASE[sound_id]+offset (ADDR_W arithmetic, no overflow check; parameters must fit).
  - On clk_8KHZ with offset < LEN-1: offset<=offset+1, rom_addr follows on the same edge.
  - On clk_8KHZ with offset == LEN-1: looping sound -> offset<=0, rom_addr<=BASE; otherwise done<=1 for one cycle, sample_en<=0, -> IDLE.
  - Strobes are ignored in IDLE and LOAD.
- Arbitration in PLAY (evaluated same cycle as req):
  - req bit j > sound_id: preempt; -> LOAD with sound j. Preempted sound dropped if non-looping; re-queued (pending bit set) if looping. No done pulse on preemption.
  - req bit j == sound_id: retrigger; offset<=0, rom_addr<=BASE, stay PLAY.
  - req bit j < sound_id: pending bit j set; played after current ends.
  - Multiple bits: highest index is acted on; the rest go to pending.
- Strobe and preemption same cycle: preemption wins, strobe ignored.
- Natural end and req same cycle: req latched into pending; selected in IDLE next cycle (end->next sound: IDLE 1 cycle, LOAD 1 cycle).
- stop: highest priority after rst. Next edge -> IDLE, pending<=0, sample_en<=0, done stays 0; req in the same cycle discarded.
- LEN==1: sound ends on first strobe in PLAY.
- Pending bit already set + new req for same sound: remains single entry, no counting.

Test Plan:
- Params N=4, BASE={0,16,32,48}, LEN={4,3,2,2}, LOOP_MASK=4'b1000. req=0001, 4 strobes -> rom_addr 0,1,2,3; done pulse on 4th strobe; sample_en low after; busy low.
- Playing sound 0 at offset 2, req=0010 -> LOAD then rom_addr=16 within 2 cycles; no done for sound 0; sound_id=1.
- Playing sound 1, req=0001 -> pending[0]=1; after sound 1 done (rom_addr 16,17,18), IDLE 1 cycle, LOAD, rom_addr=0 sound_id=0.
- req=1000 (loop) -> rom_addr 48,49,48,49... for 6 strobes, no done; stop -> sample_en=0, busy=0 next cycle, pending=0.
- Playing sound 3 (loop), req=0100 (lower) pending; req=1000 again -> retrigger rom_addr=48; stop clears pending[2], sound 2 never plays.
- rst asserted during PLAY at offset 1 -> all outputs 0 next cycle; req concurrent with rst ignored.
